// File: rtl/bound_flasher_ctrl.sv
// Bound-flasher sequencing controller: owns the counter register and phase FSM,
// steers the external next-counter generator and drives the lamp thermometer.
module bound_flasher_ctrl #(
   parameter int WIDTH     = 5,
   parameter int NUM_LAMPS = 16,
   parameter int B_TOP     = 16,
   parameter int B_MID     = 5,
   parameter int B_UP2     = 11,
   parameter int B_UP3     = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flick,
   input  logic                 abort,
   input  logic [WIDTH-1:0]     counter_n,
   output logic [WIDTH-1:0]     counter,
   output logic [1:0]           count_state,
   output logic [WIDTH-1:0]     counter_load,
   output logic                 counter_load_en,
   output logic [NUM_LAMPS-1:0] lamp,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_UP1, S_DOWN1, S_UP2, S_DOWN2, S_UP3, S_DOWN3
   } state_t;

   localparam logic [1:0] CS_INIT = 2'b00;
   localparam logic [1:0] CS_UP   = 2'b01;
   localparam logic [1:0] CS_DOWN = 2'b10;

   state_t           r_state;
   state_t           w_state_n;
   logic [WIDTH-1:0] r_counter;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_counter <= '0;
      end else begin
         r_state   <= w_state_n;
         r_counter <= counter_n;
      end
   end

   // Bounds are tested on counter_n so the state flips on the edge the
   // register lands on the bound; direction reverses on the following cycle.
   always_comb begin
      w_state_n       = r_state;
      count_state     = CS_INIT;
      counter_load    = '0;
      counter_load_en = 1'b0;
      case (r_state)
         S_IDLE: begin
            count_state = CS_INIT;
            if (flick) w_state_n = S_UP1;
         end
         S_UP1: begin
            count_state = CS_UP;
            if (counter_n == WIDTH'(B_TOP)) w_state_n = S_DOWN1;
         end
         S_DOWN1: begin
            count_state = CS_DOWN;
            if (counter_n == WIDTH'(B_MID)) w_state_n = flick ? S_UP1 : S_UP2;
         end
         S_UP2: begin
            count_state = CS_UP;
            if (counter_n == WIDTH'(B_UP2)) w_state_n = S_DOWN2;
         end
         S_DOWN2: begin
            count_state = CS_DOWN;
            if (counter_n == '0) w_state_n = flick ? S_UP2 : S_UP3;
         end
         S_UP3: begin
            count_state = CS_UP;
            if (counter_n == WIDTH'(B_UP3)) w_state_n = S_DOWN3;
         end
         S_DOWN3: begin
            count_state = CS_DOWN;
            if (counter_n == '0) w_state_n = S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
      if (abort) begin
         counter_load_en = 1'b1;
         counter_load    = '0;
         w_state_n       = S_IDLE;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LAMPS; gi++) begin : g_lamp
         assign lamp[gi] = (r_counter > WIDTH'(gi));
      end
   endgenerate

   assign counter = r_counter;
   assign busy    = (r_state != S_IDLE);

endmodule
